// File: rtl/systolic_feeder.sv
// Feeds a square systolic array: loads an N*N weight matrix, then streams activation vectors onto skewed lanes.
// Optional FEEDER_SKEW_EN: lane i delayed i+1 cycles (FLUSH 2N-1); undefined: all lanes delayed 1 cycle (FLUSH N).
module systolic_feeder #(
  parameter int unsigned DW = 32,
  parameter int unsigned N  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DW-1:0]     w_data,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [N*DW-1:0]   x_data,
  input  logic              x_last,
  output logic [N*N*DW-1:0] w_out,
  output logic              load_weights,
  output logic              start,
  output logic [N*DW-1:0]   x_out,
  output logic              busy,
  output logic              weights_loaded
);

  localparam int unsigned NW = N * N;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
`ifdef FEEDER_SKEW_EN
  localparam int unsigned FLUSH_LEN = 2 * N - 1;
`else
  localparam int unsigned FLUSH_LEN = N;
`endif
  localparam int unsigned FW = $clog2(FLUSH_LEN + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, COMMIT, STREAM, FLUSH} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_wcnt;
  logic [FW-1:0]   r_fcnt;
  logic [DW-1:0]   r_wmem [NW];
  logic            r_start;
  logic            r_wl;
  logic [N*DW-1:0] w_inject;

  // Only vectors accepted in STREAM enter the chain; every other cycle pushes a zero bubble.
  assign w_inject = (r_state == STREAM && x_valid) ? x_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_fcnt  <= '0;
      r_start <= 1'b0;
      r_wl    <= 1'b0;
      for (int k = 0; k < int'(NW); k++) r_wmem[k] <= '0;
    end else begin
      r_start <= (r_state == STREAM) || (r_state == FLUSH);
      case (r_state)
        IDLE: begin
          if (w_valid)                r_state <= LOAD_W;
          else if (x_valid && r_wl)   r_state <= STREAM;
        end
        LOAD_W: begin
          if (w_valid) begin
            r_wmem[r_wcnt] <= w_data;
            if (r_wcnt == CW'(NW - 1)) begin
              r_wcnt  <= '0;
              r_state <= COMMIT;
            end else begin
              r_wcnt <= r_wcnt + CW'(1);
            end
          end
        end
        COMMIT: begin
          r_wl    <= 1'b1;
          r_state <= IDLE;
        end
        STREAM: begin
          if (x_valid && x_last) begin
            r_fcnt  <= FW'(FLUSH_LEN);
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_fcnt <= FW'(1)) begin
            r_fcnt  <= '0;
            r_state <= IDLE;
          end else begin
            r_fcnt <= r_fcnt - FW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_ready        = (r_state == LOAD_W);
  assign x_ready        = (r_state == STREAM);
  assign load_weights   = (r_state == COMMIT);
  assign busy           = (r_state != IDLE);
  assign start          = r_start;
  assign weights_loaded = r_wl;

  genvar g;
  for (g = 0; g < int'(NW); g++) begin : g_wout
    assign w_out[g*DW +: DW] = r_wmem[g];
  end

  // Per-lane delay line; its depth sets the lane's skew.
  for (g = 0; g < int'(N); g++) begin : g_lane
`ifdef FEEDER_SKEW_EN
    localparam int unsigned D = g + 1;
`else
    localparam int unsigned D = 1;
`endif
    logic [DW-1:0] r_pipe [D];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int j = 0; j < int'(D); j++) r_pipe[j] <= '0;
      end else begin
        r_pipe[0] <= w_inject[g*DW +: DW];
        for (int j = 1; j < int'(D); j++) r_pipe[j] <= r_pipe[j-1];
      end
    end

    assign x_out[g*DW +: DW] = r_pipe[D-1];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder (N=4, DW=32); adapts lane timing to FEEDER_SKEW_EN.
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int NW = N * N;
  localparam int WW = NW * DW;
`ifdef FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int F = SKEW ? 2 * N - 1 : N;

  localparam int K_XOUT = 0, K_WREADY = 1, K_XREADY = 2, K_LOADW = 3, K_START = 4,
                 K_BUSY = 5, K_WL = 6, K_WOUT = 7, K_WORD5 = 8;

  logic              clk, reset;
  logic              w_valid, w_ready;
  logic [DW-1:0]     w_data;
  logic              x_valid, x_ready, x_last;
  logic [N*DW-1:0]   x_data, x_out;
  logic [WW-1:0]     w_out;
  logic              load_weights, start, busy, weights_loaded;

  systolic_feeder #(.DW(DW), .N(N)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .w_out(w_out), .load_weights(load_weights), .start(start), .x_out(x_out),
    .busy(busy), .weights_loaded(weights_loaded)
  );

  typedef struct {int cyc; int kind; logic [WW-1:0] val;} item_t;
  typedef struct {int e; logic [N*DW-1:0] v;} vec_t;

  item_t sb[$];
  vec_t  acc[$];
  int    cyc = 0;
  int    nvec = 0;
  int    nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic string kname(input int k);
    case (k)
      K_XOUT:   return "x_out";
      K_WREADY: return "w_ready";
      K_XREADY: return "x_ready";
      K_LOADW:  return "load_weights";
      K_START:  return "start";
      K_BUSY:   return "busy";
      K_WL:     return "weights_loaded";
      K_WOUT:   return "w_out";
      default:  return "w_out_word5";
    endcase
  endfunction

  function automatic logic [WW-1:0] actual(input int k);
    case (k)
      K_XOUT:   return WW'(x_out);
      K_WREADY: return WW'(w_ready);
      K_XREADY: return WW'(x_ready);
      K_LOADW:  return WW'(load_weights);
      K_START:  return WW'(start);
      K_BUSY:   return WW'(busy);
      K_WL:     return WW'(weights_loaded);
      K_WOUT:   return w_out;
      default:  return WW'(w_out[5*DW +: DW]);
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    logic [WW-1:0] a;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc <= cyc) begin
        nvec++;
        a = actual(sb[j].kind);
        if (sb[j].cyc < cyc || a !== sb[j].val) begin
          nerr++;
          $display("FAIL %s @cyc %0d (now %0d): got %0h expected %0h",
                   kname(sb[j].kind), sb[j].cyc, cyc, a, sb[j].val);
        end
        sb.delete(j);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int k, input logic [WW-1:0] v);
    item_t it;
    it.cyc = c; it.kind = k; it.val = v;
    sb.push_back(it);
  endtask

  task automatic push_b(input int c, input int k, input bit b);
    push(c, k, WW'(b));
  endtask

  task automatic push_all_zero(input int c);
    push(c, K_XOUT, '0);
    push(c, K_WOUT, '0);
    push_b(c, K_WREADY, 1'b0);
    push_b(c, K_XREADY, 1'b0);
    push_b(c, K_LOADW, 1'b0);
    push_b(c, K_START, 1'b0);
    push_b(c, K_BUSY, 1'b0);
    push_b(c, K_WL, 1'b0);
  endtask

  // Expected x_out for cycles e0..e1 from the planned accepts in acc.
  task automatic expect_xout(input int e0, input int e1);
    logic [N*DW-1:0] v;
    int d;
    for (int c = e0; c <= e1; c++) begin
      v = '0;
      for (int i = 0; i < N; i++) begin
        d = SKEW ? i : 0;
        foreach (acc[a]) if (acc[a].e + d == c) v[i*DW +: DW] = acc[a].v[i*DW +: DW];
      end
      push(c, K_XOUT, WW'(v));
    end
    acc.delete();
  endtask

  task automatic add_vec(input int e, input logic [N*DW-1:0] v);
    vec_t t;
    t.e = e; t.v = v;
    acc.push_back(t);
  endtask

  // Called in IDLE; streams nb weight beats base, base+1, ...
  task automatic do_load(input int base, input int nb, input bit wl_exp);
    logic [WW-1:0] ew;
    ew = '0;
    w_valid = 1'b1;
    w_data  = DW'(base);
    tick();
    x_valid = 1'b0;
    x_last  = 1'b0;
    push_b(cyc, K_BUSY, 1'b1);
    for (int k = 0; k < nb; k++) begin
      w_data = DW'(base + k);
      push_b(cyc, K_WREADY, 1'b1);
      push_b(cyc, K_WL, wl_exp);
      push_b(cyc, K_LOADW, 1'b0);
      ew[k*DW +: DW] = DW'(base + k);
      tick();
    end
    if (nb == NW) begin
      w_valid = 1'b0;
      push_b(cyc, K_LOADW, 1'b1);
      push_b(cyc, K_WREADY, 1'b0);
      push(cyc, K_WORD5, WW'(base + 5));
      tick();
      push_b(cyc, K_LOADW, 1'b0);
      push_b(cyc, K_WL, 1'b1);
      push_b(cyc, K_BUSY, 1'b0);
      push(cyc, K_WOUT, ew);
    end
  endtask

  initial begin
    int e, ea, eb;
    logic [N*DW-1:0] va, vb;
    reset = 1'b1; w_valid = 1'b0; w_data = '0;
    x_valid = 1'b0; x_data = '0; x_last = 1'b0;
    tick(); tick();
    push_all_zero(cyc);
    reset = 1'b0;
    tick();

    // Weight load 1..16
    do_load(1, NW, 1'b0);

    // Single vector with x_last
    va = {32'd40, 32'd30, 32'd20, 32'd10};
    e  = cyc + 2;
    add_vec(e, va);
    expect_xout(cyc, e + N);
    x_valid = 1'b1; x_data = va; x_last = 1'b1;
    tick();
    push_b(cyc, K_XREADY, 1'b1);
    push_b(cyc, K_START, 1'b0);
    push_b(cyc, K_BUSY, 1'b1);
    tick();
    x_valid = 1'b0; x_data = '0; x_last = 1'b0;
    push_b(cyc, K_XREADY, 1'b0);
    push_b(cyc, K_START, 1'b1);
    push_b(e + F - 1, K_BUSY, 1'b1);
    push_b(e + F, K_BUSY, 1'b0);
    push_b(e + F, K_START, 1'b1);
    push_b(e + F + 1, K_START, 1'b0);
    repeat (F + 2) tick();

    // Two vectors with a two-cycle stall between them
    va = {32'h44, 32'h33, 32'h22, 32'h11};
    vb = {32'hd4, 32'hc3, 32'hb2, 32'ha1};
    ea = cyc + 2;
    eb = cyc + 5;
    add_vec(ea, va);
    add_vec(eb, vb);
    expect_xout(cyc, eb + N);
    x_valid = 1'b1; x_data = va; x_last = 1'b0;
    tick();
    tick();
    x_valid = 1'b0; x_data = '0;
    push_b(cyc, K_START, 1'b1);
    push_b(cyc, K_XREADY, 1'b1);
    tick();
    push_b(cyc, K_START, 1'b1);
    push_b(cyc, K_XREADY, 1'b1);
    tick();
    x_valid = 1'b1; x_data = vb; x_last = 1'b1;
    push_b(cyc, K_START, 1'b1);
    tick();
    x_valid = 1'b0; x_data = '0; x_last = 1'b0;
    push_b(cyc, K_START, 1'b1);
    push_b(eb + F, K_BUSY, 1'b0);
    repeat (F + 1) tick();

    // Overwrite weights while already loaded
    do_load(50, NW, 1'b1);
    tick();

    // Reset after 7 beats discards the partial load
    do_load(100, 7, 1'b1);
    w_valid = 1'b0;
    reset = 1'b1;
    push_all_zero(cyc);
    tick();
    reset = 1'b0;
    push_all_zero(cyc);

    // x_valid ignored without weights, then w_valid wins in IDLE
    x_valid = 1'b1; x_data = {32'd8, 32'd7, 32'd6, 32'd5}; x_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      push_b(cyc, K_XREADY, 1'b0);
      push_b(cyc, K_BUSY, 1'b0);
      push(cyc, K_XOUT, '0);
    end
    do_load(200, NW, 1'b0);

    repeat (3) tick();

    nvec++;
    if (weights_loaded !== 1'b1) begin
      nerr++;
      $display("FAIL final weights_loaded: got %0b expected 1", weights_loaded);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL final busy: got %0b expected 0", busy);
    end
    nvec++;
    if (load_weights !== 1'b0) begin
      nerr++;
      $display("FAIL final load_weights: got %0b expected 0", load_weights);
    end
    nvec++;
    if (w_ready !== 1'b0 || x_ready !== 1'b0) begin
      nerr++;
      $display("FAIL final ready: w_ready=%0b x_ready=%0b expected 0/0", w_ready, x_ready);
    end
    nvec++;
    if (w_out[5*DW +: DW] !== DW'(205)) begin
      nerr++;
      $display("FAIL final w_out word5: got %0d expected 205", w_out[5*DW +: DW]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    if (nerr != 0) $display("FAIL: %0d miscompares", nerr);
    else           $display("PASS");
    $finish;
  end

endmodule
